// File: rtl/control_sequencer.sv
// control_sequencer: handshake-driven i16 decode sequencer with a saturating retire counter.
// Optional MUL/DIV watchdog is built only when CU_TIMEOUT_EN is defined.
module control_sequencer #(
  parameter int OP_W           = 3,
  parameter int ALU_OP_W       = 1,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OP_W-1:0]     opcode,
  output logic [ALU_OP_W-1:0] alu_opcode,
  output logic                use_immediate,
  output logic                load_upper_immediate,
  output logic                alu_start,
  input  logic                alu_done,
  output logic                reg_write,
  output logic                busy,
  output logic                illegal_op,
  output logic                timeout,
  output logic [CNT_W-1:0]    retire_count
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] EXEC = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] WB   = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  if (OP_W < 3 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("control_sequencer: OP_W must be >= 3 and TIMEOUT_CYCLES >= 1");
  end

  logic [2:0]          state_q, state_d;
  logic [ALU_OP_W-1:0] alu_q, alu_d;
  logic                imm_q, imm_d, lui_q, lui_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op3;
  logic                accept, legal, is_mul, is_imm, is_lui, abort;

  assign op3    = opcode[2:0];
  assign legal  = ((opcode >> 3) == '0) && (op3 != 3'b100) && (op3 != 3'b101) && (op3 != 3'b110);
  assign is_mul = (op3 == 3'b111) || (op3 == 3'b001);
  assign is_imm = (op3 == 3'b001) || (op3 == 3'b010);
  assign is_lui = (op3 == 3'b011);
  assign accept = instr_valid && (state_q == IDLE);

`ifdef CU_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
  // done on the limit cycle takes priority over the abort
  assign abort = (state_q == WAIT) && !alu_done && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  always_comb begin
    wd_d = (state_q == WAIT) ? (alu_done ? wd_q : wd_q + 1'b1) : '0;
    to_d = abort;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  assign timeout = to_q;
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = accept ? (legal ? (is_lui ? WB : EXEC) : ERR) : IDLE;
      EXEC:    state_d = WAIT;
      WAIT:    state_d = alu_done ? WB : (abort ? IDLE : WAIT);
      default: state_d = IDLE;
    endcase
    alu_d = (accept && legal) ? ALU_OP_W'(is_mul) : alu_q;
    imm_d = (accept && legal) ? is_imm : imm_q;
    lui_d = (accept && legal) ? is_lui : lui_q;
    cnt_d = (state_q == WB && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      alu_q   <= '0;
      imm_q   <= 1'b0;
      lui_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      imm_q   <= imm_d;
      lui_q   <= lui_d;
      cnt_q   <= cnt_d;
    end

  assign instr_ready          = (state_q == IDLE);
  assign busy                 = (state_q != IDLE);
  assign alu_start            = (state_q == EXEC);
  assign reg_write            = (state_q == WB);
  assign illegal_op           = (state_q == ERR);
  assign alu_opcode           = alu_q;
  assign use_immediate        = imm_q;
  assign load_upper_immediate = lui_q;
  assign retire_count         = cnt_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of decode, sequencing, reset, saturation and the optional watchdog.
module tb_control_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic valid = 1'b0, done = 1'b0;
  logic [2:0] op = 3'b000;
  logic ready, alu_op, imm, lui, start, wr, busy, ill, to;
  logic [15:0] cnt;
  logic s_valid = 1'b0;
  logic s_ready, s_alu, s_imm, s_lui, s_start, s_wr, s_busy, s_ill, s_to;
  logic [1:0] s_cnt;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  control_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(valid), .instr_ready(ready), .opcode(op),
    .alu_opcode(alu_op), .use_immediate(imm), .load_upper_immediate(lui), .alu_start(start),
    .alu_done(done), .reg_write(wr), .busy(busy), .illegal_op(ill), .timeout(to), .retire_count(cnt)
  );

  control_sequencer #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .instr_valid(s_valid), .instr_ready(s_ready), .opcode(3'b011),
    .alu_opcode(s_alu), .use_immediate(s_imm), .load_upper_immediate(s_lui), .alu_start(s_start),
    .alu_done(1'b0), .reg_write(s_wr), .busy(s_busy), .illegal_op(s_ill), .timeout(s_to), .retire_count(s_cnt)
  );

`ifdef CU_TIMEOUT_EN
  logic t_valid = 1'b0, t_done = 1'b0;
  logic t_ready, t_alu, t_imm, t_lui, t_start, t_wr, t_busy, t_ill, t_to;
  logic [15:0] t_cnt;
  control_sequencer #(.TIMEOUT_CYCLES(8)) u_to (
    .clk(clk), .rst_n(rst_n), .instr_valid(t_valid), .instr_ready(t_ready), .opcode(3'b111),
    .alu_opcode(t_alu), .use_immediate(t_imm), .load_upper_immediate(t_lui), .alu_start(t_start),
    .alu_done(t_done), .reg_write(t_wr), .busy(t_busy), .illegal_op(t_ill), .timeout(t_to), .retire_count(t_cnt)
  );
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", cnt); end
    checks++; if ({start, wr, ill, to, alu_op, imm, lui} !== 7'b0) begin failures++; $display("FAIL rst_outs got=%b exp=0", {start, wr, ill, to, alu_op, imm, lui}); end
    rst_n = 1'b1;
    tick;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL idle_after_rst got=%b%b exp=10", ready, busy); end
  endtask

  task automatic test_lui;
    valid = 1'b1; op = 3'b011;
    tick;
    valid = 1'b0;
    checks++; if (lui !== 1'b1) begin failures++; $display("FAIL lui_sel got=%b exp=1", lui); end
    checks++; if (wr !== 1'b1) begin failures++; $display("FAIL lui_wr got=%b exp=1", wr); end
    checks++; if (ready !== 1'b0 || start !== 1'b0) begin failures++; $display("FAIL lui_wb got=%b%b exp=00", ready, start); end
    tick;
    checks++; if (ready !== 1'b1 || wr !== 1'b0) begin failures++; $display("FAIL lui_idle got=%b%b exp=10", ready, wr); end
    checks++; if (cnt !== 16'd1) begin failures++; $display("FAIL lui_cnt got=%0d exp=1", cnt); end
  endtask

  task automatic test_muli;
    int starts;
    valid = 1'b1; op = 3'b001;
    tick;
    starts = int'(start);
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL muli_start got=%b exp=1", start); end
    checks++; if (alu_op !== 1'b1 || imm !== 1'b1 || lui !== 1'b0) begin failures++; $display("FAIL muli_dec got=%b%b%b exp=110", alu_op, imm, lui); end
    for (int i = 0; i < 3; i++) begin
      tick;
      starts += int'(start);
      checks++; if (busy !== 1'b1 || ready !== 1'b0 || wr !== 1'b0) begin failures++; $display("FAIL muli_wait%0d got=%b%b%b exp=100", i, busy, ready, wr); end
    end
    done = 1'b1;
    tick;
    done = 1'b0;
    starts += int'(start);
    checks++; if (wr !== 1'b1) begin failures++; $display("FAIL muli_wr got=%b exp=1", wr); end
    checks++; if (starts != 1) begin failures++; $display("FAIL muli_starts got=%0d exp=1", starts); end
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL muli_to got=%b exp=0", to); end
    valid = 1'b0;
    tick;
    checks++; if (cnt !== 16'd2 || ready !== 1'b1) begin failures++; $display("FAIL muli_cnt got=%0d,%b exp=2,1", cnt, ready); end
  endtask

  task automatic test_back_to_back;
    valid = 1'b1; op = 3'b101;
    tick;
    checks++; if (ill !== 1'b1 || wr !== 1'b0) begin failures++; $display("FAIL ill_pulse got=%b%b exp=10", ill, wr); end
    checks++; if (alu_op !== 1'b1 || imm !== 1'b1) begin failures++; $display("FAIL ill_hold got=%b%b exp=11", alu_op, imm); end
    op = 3'b000;
    tick;
    checks++; if (ill !== 1'b0 || cnt !== 16'd2 || ready !== 1'b1) begin failures++; $display("FAIL ill_after got=%b,%0d,%b exp=0,2,1", ill, cnt, ready); end
    tick;
    valid = 1'b0;
    checks++; if (start !== 1'b1 || alu_op !== 1'b0 || imm !== 1'b0) begin failures++; $display("FAIL div_dec got=%b%b%b exp=100", start, alu_op, imm); end
    tick;
    done = 1'b1;
    tick;
    done = 1'b0;
    checks++; if (wr !== 1'b1) begin failures++; $display("FAIL div_wr got=%b exp=1", wr); end
    tick;
    checks++; if (cnt !== 16'd3) begin failures++; $display("FAIL div_cnt got=%0d exp=3", cnt); end
  endtask

  task automatic test_done_ignored;
    done = 1'b1;
    tick;
    done = 1'b0;
    checks++; if (busy !== 1'b0 || wr !== 1'b0 || cnt !== 16'd3) begin failures++; $display("FAIL idle_done got=%b%b,%0d exp=00,3", busy, wr, cnt); end
  endtask

  task automatic test_reset_mid;
    valid = 1'b1; op = 3'b111;
    tick;
    valid = 1'b0;
    tick;
    checks++; if (busy !== 1'b1 || start !== 1'b0) begin failures++; $display("FAIL mid_wait got=%b%b exp=10", busy, start); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL mid_rst_state got=%b%b exp=01", busy, ready); end
    checks++; if ({start, wr, ill, to, alu_op, imm, lui} !== 7'b0 || cnt !== 16'd0) begin failures++; $display("FAIL mid_rst_outs got=%b,%0d exp=0,0", {start, wr, ill, to, alu_op, imm, lui}, cnt); end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_saturation;
    logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      tick;
      checks++; if (s_cnt !== exp[k]) begin failures++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", k, s_cnt, exp[k]); end
    end
    s_valid = 1'b0;
  endtask

`ifdef CU_TIMEOUT_EN
  task automatic test_timeout;
    t_valid = 1'b1;
    tick;
    t_valid = 1'b0;
    tick;
    for (int k = 1; k < 8; k++) begin
      tick;
      checks++; if (t_to !== 1'b0 || t_busy !== 1'b1) begin failures++; $display("FAIL to_wait%0d got=%b%b exp=01", k, t_to, t_busy); end
    end
    tick;
    checks++; if (t_to !== 1'b1 || t_busy !== 1'b0 || t_wr !== 1'b0) begin failures++; $display("FAIL to_abort got=%b%b%b exp=100", t_to, t_busy, t_wr); end
    tick;
    checks++; if (t_to !== 1'b0 || t_cnt !== 16'd0) begin failures++; $display("FAIL to_after got=%b,%0d exp=0,0", t_to, t_cnt); end
    t_valid = 1'b1;
    tick;
    t_valid = 1'b0;
    tick;
    for (int k = 1; k < 8; k++) tick;
    t_done = 1'b1;
    tick;
    t_done = 1'b0;
    checks++; if (t_wr !== 1'b1 || t_to !== 1'b0) begin failures++; $display("FAIL to_done_wins got=%b%b exp=10", t_wr, t_to); end
    tick;
    checks++; if (t_to !== 1'b0 || t_cnt !== 16'd1) begin failures++; $display("FAIL to_done_cnt got=%b,%0d exp=0,1", t_to, t_cnt); end
  endtask
`endif

  initial begin
    test_reset;
    test_lui;
    test_muli;
    test_back_to_back;
    test_done_ignored;
    test_reset_mid;
    test_saturation;
`ifdef CU_TIMEOUT_EN
    test_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle successor to the combinational opcode decoder in the i16 core.
- Accepts one instruction per valid/ready handshake and registers the decoded controls (ALU opcode, immediate select, LUI select).
- Sequences the MUL/DIV ALU through start/done, then issues a one-cycle register write.
- Flags illegal opcodes instead of silently defaulting, and keeps a saturating retired-instruction counter.

Parameters:
- OP_W, 3: opcode width, minimum 3.
- ALU_OP_W, 1: ALU opcode width.
- CNT_W, 16: retired-instruction counter width.
- TIMEOUT_CYCLES, 64: watchdog limit in WAIT, in cycles. Used only with CU_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  upstream has an instruction.
- instr_ready  out  1  sequencer can accept an instruction.
- opcode  in  OP_W  instruction opcode.
- alu_opcode  out  ALU_OP_W  1 = multiply, 0 = divide, zero-extended.
- use_immediate  out  1  ALU operand B comes from the immediate.
- load_upper_immediate  out  1  write-back source is the LUI path.
- alu_start  out  1  one-cycle ALU launch pulse.
- alu_done  in  1  ALU result valid, one-cycle pulse.
- reg_write  out  1  register-file write enable, one-cycle pulse.
- busy  out  1  high when state is not IDLE.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- timeout  out  1  one-cycle pulse on a watchdog abort.
- retire_count  out  CNT_W  number of completed write-backs.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: state goes to IDLE immediately, including mid-operation. All outputs are 0 except instr_ready = 1. retire_count = 0. The watchdog counter = 0.
- Opcode decode (legal only when bits [OP_W-1:3] are all zero):
  - 111 MUL: alu = 1, imm = 0
  - 000 DIV: alu = 0, imm = 0
  - 001 MULi: alu = 1, imm = 1
  - 010 DIVi: alu = 0, imm = 1
  - 011 LUI: alu = 0, imm = 0, lui = 1
  - Every other value is illegal.
- States: IDLE, EXEC, WAIT, WB, ERR. All outputs are registered or derived only from state.
- IDLE:
  - instr_ready = 1.
  - Accept happens when instr_valid & instr_ready at a rising edge.
  - On a legal accept, alu_opcode, use_immediate and load_upper_immediate are loaded at that edge.
  - Next state: LUI goes to WB; MUL/DIV family goes to EXEC; illegal goes to ERR, and the decoded outputs are left unchanged.
- EXEC: alu_start = 1 for exactly this cycle; next state is WAIT.
- WAIT:
  - Stays in WAIT until alu_done = 1, then goes to WB.
  - alu_done asserted in any state other than WAIT is ignored.
- WB: reg_write = 1 for this cycle only. retire_count increments and saturates at all-ones (no wrap). Next state is IDLE.
- ERR: illegal_op = 1 for this cycle only. No reg_write and no count. Next state is IDLE.
- instr_ready = 0 in every state except IDLE. No instruction is accepted while busy = 1.
- Decoded outputs hold stable from the accept edge until the next legal accept.
- Latency from the accept edge:
  - LUI: reg_write in the next cycle, so throughput is 1 instruction per 2 cycles.
  - MUL/DIV: alu_start at +1; reg_write one cycle after the alu_done cycle. Minimum 4 cycles per instruction.
- Illegal opcode: 2 cycles per instruction.

Optional Feature:
- Macro: CU_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments on each WAIT cycle without alu_done.
  - When it reaches TIMEOUT_CYCLES, the sequencer goes to IDLE. The abort cycle pulses timeout = 1 for one cycle, with no reg_write and no retire increment.
  - If alu_done arrives in the same cycle the limit is reached, done wins and the sequencer goes to WB.
- Not defined: WAIT lasts indefinitely, timeout is tied to 0, and no watchdog logic exists.

Test Plan:
- Reset release, then idle: retire_count = 0, instr_ready = 1, busy = 0. Assert rst_n = 0 while in WAIT: state returns to IDLE in the same cycle, all pulses are 0, retire_count = 0.
- LUI (opcode 011) accepted at edge T: load_upper_immediate = 1 after T, reg_write = 1 in the cycle after T, instr_ready = 1 again after that, retire_count = 1.
- MULi (001) accepted, alu_done returned 3 cycles after alu_start: alu_opcode = 1, use_immediate = 1, exactly one alu_start pulse, reg_write in the cycle after done. instr_valid held high throughout is not re-accepted until IDLE.
- Opcode 101, then DIV (000) back-to-back: illegal_op pulses once with no reg_write and no count change. DIV then completes with alu_opcode = 0 and retire_count incremented by 1.
- CNT_W = 2, five LUIs: retire_count goes 1, 2, 3, 3, 3 (saturates, no wrap).
- With CU_TIMEOUT_EN and TIMEOUT_CYCLES = 8, MUL with alu_done never asserted: timeout pulses once 8 cycles after WAIT entry, no reg_write, back to IDLE. Repeat with done on the limit cycle: reg_write occurs and timeout stays 0.
